// File: rtl/md_unit_if.sv
// md_unit_if: MDU issue/result bundle; master=EX-stage issuer (start/op/A/B/cancel), slave=md_unit (isbusy/done/HI/LO)
interface md_unit_if #(parameter int WIDTH = 32);
  logic             MDU_start;
  logic [2:0]       MDU_op;
  logic [WIDTH-1:0] MDU_A;
  logic [WIDTH-1:0] MDU_B;
  logic             MDU_cancel;
  logic             isbusy;
  logic             MDU_done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  modport master (output MDU_start, MDU_op, MDU_A, MDU_B, MDU_cancel, input isbusy, MDU_done, HI, LO);
  modport slave  (input MDU_start, MDU_op, MDU_A, MDU_B, MDU_cancel, output isbusy, MDU_done, HI, LO);
endinterface

// File: rtl/md_unit.sv
// md_unit: iterative mul/div with HI/LO; ports clk, rst (async high), bus (md_unit_if.slave); MDU_FAST_MUL_EN selects single-cycle multiply
module md_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic       clk,
  input logic       rst,
  md_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] ma, mb, hi, lo;
  logic sa, sb, md_div, done;
  logic go, accept, accept_it, signed_op, a_neg, b_neg, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0] mul_sum, div_rem, div_sub;
  logic div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign go        = bus.MDU_start & ~bus.MDU_cancel & (state == IDLE);
  assign accept    = go & (bus.MDU_op <= 3'd3);
`ifdef MDU_FAST_MUL_EN
  // multiplies finish at issue, so only divides enter the FSM
  assign accept_it = accept & bus.MDU_op[1];
`else
  assign accept_it = accept;
`endif
  assign bus.isbusy   = (state != IDLE) | (bus.MDU_start & ~bus.MDU_cancel & (bus.MDU_op <= 3'd3));
  assign bus.MDU_done = done;
  assign bus.HI       = hi;
  assign bus.LO       = lo;
  assign signed_op = ~bus.MDU_op[0];
  assign a_neg     = signed_op & bus.MDU_A[WIDTH-1];
  assign b_neg     = signed_op & bus.MDU_B[WIDTH-1];
  assign a_mag     = a_neg ? -bus.MDU_A : bus.MDU_A;
  assign b_mag     = b_neg ? -bus.MDU_B : bus.MDU_B;
  assign last      = cnt == CNT_W'(WIDTH - 1);
  // multiply: acc = {carry+partial(W+1), multiplier(W)}, shifted right each step
  assign mul_sum   = acc[0] ? acc[2*WIDTH:WIDTH] + {1'b0, ma} : acc[2*WIDTH:WIDTH];
  // divide: acc[2W-1:W]=rem, acc[W-1:0]=quo; shifted remainder needs W+1 bits
  assign div_rem   = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_rem >= {1'b0, mb};
  assign div_sub   = div_ge ? div_rem - {1'b0, mb} : div_rem;
  assign prod_fix  = (sa ^ sb) ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
  assign quo_fix   = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix   = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = accept_it ? (bus.MDU_op[1] ? DIV : MUL) : IDLE;
    else state_nx = (bus.MDU_cancel || state == FIX) ? IDLE : last ? FIX : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      ma     <= '0;
      mb     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      md_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_it) begin
        ma     <= a_mag;
        mb     <= b_mag;
        sa     <= a_neg;
        sb     <= b_neg;
        md_div <= bus.MDU_op[1];
        cnt    <= '0;
        acc    <= {{(WIDTH+1){1'b0}}, bus.MDU_op[1] ? a_mag : b_mag};
      end else if (state == MUL) begin
        acc <= {1'b0, mul_sum, acc[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
      end else if (state == DIV) begin
        acc <= {div_sub, acc[WIDTH-2:0], div_ge};
        cnt <= cnt + 1'b1;
      end
      if (state == FIX && !bus.MDU_cancel) begin
        {hi, lo} <= md_div ? {rem_fix, quo_fix} : prod_fix;
        done     <= 1'b1;
      end
      if (go && bus.MDU_op == 3'd4) hi <= bus.MDU_A;
      if (go && bus.MDU_op == 3'd5) lo <= bus.MDU_A;
`ifdef MDU_FAST_MUL_EN
      if (accept && !bus.MDU_op[1]) begin
        {hi, lo} <= {{WIDTH{a_neg}}, bus.MDU_A} * {{WIDTH{b_neg}}, bus.MDU_B};
        done     <= 1'b1;
      end
`endif
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed checks of md_unit (latency, signs, div-by-zero, cancel, reset)
module tb_md_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n = 0;
  int errs = 0;
  int busy, done_at;
  bit saw_done;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 0, MUL_BUSY = 1;
`else
  localparam int MUL_LAT = 33, MUL_BUSY = 34;
`endif
  md_unit_if #(.WIDTH(32)) bus ();
  md_unit #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    busy = 0;
    done_at = -1;
    bus.MDU_start = 1'b1;
    bus.MDU_op = op;
    bus.MDU_A = a;
    bus.MDU_B = b;
    #1;
    if (bus.isbusy) busy++;
    for (int k = 0; k < 100; k++) begin
      tick();
      bus.MDU_start = 1'b0;
      if (bus.MDU_done) done_at = k;
      if (!bus.isbusy) break;
      busy++;
    end
  endtask
  initial begin
    bus.MDU_start = 1'b0;
    bus.MDU_op = 3'd0;
    bus.MDU_A = '0;
    bus.MDU_B = '0;
    bus.MDU_cancel = 1'b0;
    tick();
    chk("rst_hi", bus.HI, 0);
    chk("rst_lo", bus.LO, 0);
    chk("rst_busy", bus.isbusy, 0);
    chk("rst_done", bus.MDU_done, 0);
    rst = 1'b0;
    tick();
    run(3'd3, 100, 7);
    chk("divu_busy", busy, 34);
    chk("divu_done_at", done_at, 33);
    chk("divu_lo", bus.LO, 14);
    chk("divu_hi", bus.HI, 2);
    tick();
    chk("divu_done_pulse", bus.MDU_done, 0);
    run(3'd2, 32'hFFFF_FFF9, 2);
    chk("div_neg_lo", bus.LO, 32'hFFFF_FFFD);
    chk("div_neg_hi", bus.HI, 32'hFFFF_FFFF);
    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo", bus.LO, 32'h8000_0000);
    chk("div_ovf_hi", bus.HI, 0);
    run(3'd0, 32'hFFFF_FFFD, 5);
    chk("mult_prod", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("mult_busy", busy, MUL_BUSY);
    chk("mult_done_at", done_at, MUL_LAT);
    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_hi", bus.HI, 32'hFFFF_FFFE);
    chk("multu_lo", bus.LO, 32'h0000_0001);
    run(3'd4, 32'h11, 0);
    chk("mthi_busy", busy, 0);
    chk("mthi_done", bus.MDU_done, 0);
    run(3'd5, 32'h22, 0);
    chk("mthi_hi", bus.HI, 32'h11);
    chk("mtlo_lo", bus.LO, 32'h22);
    bus.MDU_start = 1'b1;
    bus.MDU_op = 3'd3;
    bus.MDU_A = 9;
    bus.MDU_B = 0;
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      bus.MDU_start = 1'b0;
      saw_done |= bus.MDU_done;
    end
    chk("cancel_busy_before", bus.isbusy, 1);
    bus.MDU_cancel = 1'b1;
    tick();
    bus.MDU_cancel = 1'b0;
    saw_done |= bus.MDU_done;
    chk("cancel_busy", bus.isbusy, 0);
    chk("cancel_hi", bus.HI, 32'h11);
    chk("cancel_lo", bus.LO, 32'h22);
    tick();
    saw_done |= bus.MDU_done;
    chk("cancel_no_done", saw_done, 0);
    run(3'd3, 9, 0);
    chk("divz_lo", bus.LO, 32'hFFFF_FFFF);
    chk("divz_hi", bus.HI, 9);
    bus.MDU_cancel = 1'b1;
    run(3'd3, 50, 5);
    bus.MDU_cancel = 1'b0;
    chk("startcan_busy", busy, 0);
    chk("startcan_lo", bus.LO, 32'hFFFF_FFFF);
    chk("startcan_hi", bus.HI, 9);
    run(3'd6, 32'h55, 3);
    chk("nop_busy", busy, 0);
    chk("nop_hi", bus.HI, 9);
    bus.MDU_start = 1'b1;
    bus.MDU_op = 3'd2;
    bus.MDU_A = 1000;
    bus.MDU_B = 32'hFFFF_FFFD;
    for (int k = 0; k < 15; k++) begin
      tick();
      bus.MDU_start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midrst_hi", bus.HI, 0);
    chk("midrst_lo", bus.LO, 0);
    chk("midrst_busy", bus.isbusy, 0);
    tick();
    rst = 1'b0;
    tick();
    run(3'd3, 10, 3);
    chk("post_rst_lo", bus.LO, 3);
    chk("post_rst_hi", bus.HI, 1);
    chk("post_rst_busy", busy, 34);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
